// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the 16-bit RISC core pipeline.
// Holds the ID/EX register layout and the producer-match helper used by the forwarding muxes.
package risc_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = 3'd0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_PASS = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rd;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
  } ex_regs_t;

  localparam ex_regs_t EX_BUBBLE = {$bits(ex_regs_t){1'b0}};

  // True when an enabled producer writes the register being read.
  function automatic logic reg_match(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return we & (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand selector: r0, then the youngest in-flight producer, then RF read data.
module fwd_mux
  import risc_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op
);

  // Youngest matching producer wins; WB still wins over RF because RF writes only at the edge.
  always_comb begin
    op = rf_data;
    if (rs == REG_ZERO) begin
      op = {DATA_W{1'b0}};
    end else if (reg_match(ex_fwd_en, ex_rd, rs)) begin
      op = ex_alu_result;
    end else if (reg_match(mem_reg_write, mem_rd, rs)) begin
      op = mem_data;
    end else if (reg_match(wb_reg_write, wb_rd, rs)) begin
      op = wb_data;
    end else begin
      op = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard handling.
// stall_id is combinational; all ex_* outputs come straight from the register.
module id_ex_stage
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_uses_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  rf_data_1,
  input  logic [DATA_W-1:0]  rf_data_2,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic               mem_reg_write,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               wb_reg_write,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_op_a,
  output logic [DATA_W-1:0]  ex_op_b
);

  ex_regs_t          ex_r;
  ex_regs_t          ex_load_s;
  logic              ex_fwd_en_s;
  logic              load_use_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;

  // A load in EX has no data yet, so it is never an EX forwarding source.
  assign ex_fwd_en_s = ex_r.valid & ex_r.reg_write & ~ex_r.mem_read;

  assign load_use_s = id_valid & ex_r.valid & ex_r.mem_read & (ex_r.rd != REG_ZERO) &
                      ((ex_r.rd == id_rs1) | (id_uses_rs2 & (ex_r.rd == id_rs2)));

  assign stall_id = load_use_s | ex_stall;

  fwd_mux u_fwd_a (
    .rs(id_rs1), .rf_data(rf_data_1),
    .ex_fwd_en(ex_fwd_en_s), .ex_rd(ex_r.rd), .ex_alu_result(ex_alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .op(op_a_s)
  );

  fwd_mux u_fwd_b (
    .rs(id_rs2), .rf_data(rf_data_2),
    .ex_fwd_en(ex_fwd_en_s), .ex_rd(ex_r.rd), .ex_alu_result(ex_alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .op(op_b_s)
  );

  // Next EX contents for a normal advance; an empty decode slot carries no side effects.
  always_comb begin
    ex_load_s           = EX_BUBBLE;
    ex_load_s.valid     = id_valid;
    ex_load_s.rd        = id_rd;
    ex_load_s.reg_write = id_valid & id_reg_write;
    ex_load_s.mem_read  = id_valid & id_mem_read;
    ex_load_s.mem_write = id_valid & id_mem_write;
    ex_load_s.alu_op    = id_alu_op;
    ex_load_s.imm       = id_imm;
    ex_load_s.op_a      = op_a_s;
    ex_load_s.op_b      = op_b_s;
  end

  // Pipeline register: reset > flush > downstream hold > load-use bubble > advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_r <= EX_BUBBLE;
    end else if (ex_stall) begin
      ex_r <= ex_r;
    end else if (load_use_s) begin
      ex_r <= EX_BUBBLE;
    end else begin
      ex_r <= ex_load_s;
    end
  end

  assign ex_valid     = ex_r.valid;
  assign ex_rd        = ex_r.rd;
  assign ex_reg_write = ex_r.reg_write;
  assign ex_mem_read  = ex_r.mem_read;
  assign ex_mem_write = ex_r.mem_write;
  assign ex_alu_op    = ex_r.alu_op;
  assign ex_imm       = ex_r.imm;
  assign ex_op_a      = ex_r.op_a;
  assign ex_op_b      = ex_r.op_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding table, directed hazard/stall/flush
// sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic [2:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [3:0]  id_alu_op;
  logic [15:0] id_imm, rf_data_1, rf_data_2, ex_alu_result, mem_data, wb_data;
  logic        mem_reg_write, wb_reg_write, ex_stall, flush;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_imm, ex_op_a, ex_op_b;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .id_imm(id_imm), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_data(mem_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
  );

  typedef struct packed {
    logic valid; logic [2:0] rd; logic rw, mr, mw; logic [3:0] op;
    logic [15:0] imm, a, b;
  } st_t;

  st_t dut_s;
  assign dut_s = {ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                  ex_alu_op, ex_imm, ex_op_a, ex_op_b};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 1'b0; id_valid = 1'b0; id_uses_rs2 = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_rd = 3'd0;
    id_alu_op = 4'd0; id_imm = 16'h0; rf_data_1 = 16'h0; rf_data_2 = 16'h0;
    ex_alu_result = 16'h0; mem_rd = 3'd0; mem_reg_write = 1'b0; mem_data = 16'h0;
    wb_rd = 3'd0; wb_reg_write = 1'b0; wb_data = 16'h0; ex_stall = 1'b0; flush = 1'b0;
  endtask

  // ---- reference model: newest writer of a register supplies its value ----
  function automatic logic [15:0] resolve(input logic [2:0] rs, input logic [15:0] rf, input st_t m);
    logic        en_q [3];
    logic [2:0]  rd_q [3];
    logic [15:0] d_q  [3];
    if (rs == 3'd0) return 16'h0;
    en_q = '{m.valid && m.rw && !m.mr, mem_reg_write, wb_reg_write};
    rd_q = '{m.rd, mem_rd, wb_rd};
    d_q  = '{ex_alu_result, mem_data, wb_data};
    for (int k = 0; k < 3; k++)
      if (en_q[k] && rd_q[k] == rs) return d_q[k];
    return rf;
  endfunction

  function automatic logic model_load_use(input st_t m);
    logic needs_ex;
    needs_ex = (m.rd == id_rs1) || (id_uses_rs2 && m.rd == id_rs2);
    return id_valid && m.valid && m.mr && m.rd != 3'd0 && needs_ex;
  endfunction

  function automatic st_t model_next(input st_t m);
    st_t n;
    n = '0;
    if (rst || flush) n = '0;
    else if (ex_stall) n = m;
    else if (model_load_use(m)) n = '0;
    else begin
      n.valid = id_valid; n.rd = id_rd; n.rw = id_valid && id_reg_write;
      n.mr = id_valid && id_mem_read; n.mw = id_valid && id_mem_write;
      n.op = id_alu_op; n.imm = id_imm;
      n.a = resolve(id_rs1, rf_data_1, m);
      n.b = resolve(id_rs2, rf_data_2, m);
    end
    return n;
  endfunction

  // ---- forwarding vectors (EX holds no writer while these run) ----
  typedef struct {
    logic [2:0] rs1, rs2; logic [15:0] rf1, rf2;
    logic mwe; logic [2:0] mrd; logic [15:0] md;
    logic wwe; logic [2:0] wrd; logic [15:0] wd;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [6];
  st_t  held;
  st_t  m;

  initial begin
    vecs[0] = '{3'd3, 3'd3, 16'h1111, 16'h1111, 1'b1, 3'd3, 16'h3333, 1'b1, 3'd3, 16'h2222, 16'h3333, 16'h3333};
    vecs[1] = '{3'd3, 3'd3, 16'h1111, 16'h1111, 1'b0, 3'd3, 16'h3333, 1'b1, 3'd3, 16'h2222, 16'h2222, 16'h2222};
    vecs[2] = '{3'd3, 3'd3, 16'h1111, 16'h1111, 1'b0, 3'd3, 16'h3333, 1'b0, 3'd3, 16'h2222, 16'h1111, 16'h1111};
    vecs[3] = '{3'd0, 3'd6, 16'h1234, 16'h6666, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd6, 16'h0606, 16'h0000, 16'h0606};
    vecs[4] = '{3'd2, 3'd2, 16'h0002, 16'h0002, 1'b0, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 16'hBBBB, 16'hBBBB};
    vecs[5] = '{3'd7, 3'd5, 16'h7777, 16'h5555, 1'b1, 3'd5, 16'h0505, 1'b0, 3'd7, 16'hCCCC, 16'h7777, 16'h0505};

    // reset
    clear_in();
    rst = 1'b1;
    step(); step();
    chk("reset_state", dut_s, 64'h0);
    chk("reset_stall_id", stall_id, 1'b0);
    rst = 1'b0;

    // forwarding precedence table
    foreach (vecs[i]) begin
      id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rd = 3'd1;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      rf_data_1 = vecs[i].rf1; rf_data_2 = vecs[i].rf2;
      mem_reg_write = vecs[i].mwe; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      wb_reg_write = vecs[i].wwe; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
      step();
      chk($sformatf("fwd_vec%0d_a", i), ex_op_a, vecs[i].exp_a);
      chk($sformatf("fwd_vec%0d_b", i), ex_op_b, vecs[i].exp_b);
    end
    clear_in();

    // EX-stage forward, no stall
    id_valid = 1'b1; id_rd = 3'd2; id_reg_write = 1'b1; id_alu_op = 4'd0;
    step();
    id_rd = 3'd5; id_reg_write = 1'b0; id_rs1 = 3'd1; id_rs2 = 3'd2; id_uses_rs2 = 1'b1;
    rf_data_1 = 16'h0001; rf_data_2 = 16'hDEAD; ex_alu_result = 16'h00A5;
    #1 chk("exfwd_no_stall", stall_id, 1'b0);
    step();
    chk("exfwd_op_b", ex_op_b, 16'h00A5);
    chk("exfwd_op_a", ex_op_a, 16'h0001);

    // load-use: one bubble, then MEM forward
    clear_in();
    id_valid = 1'b1; id_rd = 3'd4; id_reg_write = 1'b1; id_mem_read = 1'b1;
    step();
    id_mem_read = 1'b0; id_rd = 3'd5; id_rs1 = 3'd4; id_rs2 = 3'd1; id_uses_rs2 = 1'b1;
    rf_data_2 = 16'h0077;
    #1 chk("lu_stall", stall_id, 1'b1);
    step();
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_bubble_rw", ex_reg_write, 1'b0);
    chk("lu_stall_released", stall_id, 1'b0);
    mem_rd = 3'd4; mem_reg_write = 1'b1; mem_data = 16'hBEEF;
    step();
    chk("lu_fwd_a", ex_op_a, 16'hBEEF);
    chk("lu_fwd_b", ex_op_b, 16'h0077);
    chk("lu_valid", ex_valid, 1'b1);

    // load of r0 never stalls
    clear_in();
    id_valid = 1'b1; id_rd = 3'd0; id_reg_write = 1'b1; id_mem_read = 1'b1;
    step();
    id_mem_read = 1'b0; id_reg_write = 1'b0; id_uses_rs2 = 1'b1;
    #1 chk("lw_r0_no_stall", stall_id, 1'b0);
    step();

    // flush beats ex_stall, then a 3-cycle hold
    clear_in();
    id_valid = 1'b1; id_rd = 3'd3; id_reg_write = 1'b1; id_mem_write = 1'b1; id_imm = 16'h1234;
    step();
    chk("pre_flush_valid", ex_valid, 1'b1);
    flush = 1'b1; ex_stall = 1'b1;
    #1 chk("flush_stall_id", stall_id, 1'b1);
    step();
    chk("flush_bubble", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 4'b0000);
    flush = 1'b0; ex_stall = 1'b0;
    id_rd = 3'd6; id_mem_write = 1'b0; id_alu_op = 4'd7; id_imm = 16'h5A5A;
    id_rs1 = 3'd1; id_rs2 = 3'd2; id_uses_rs2 = 1'b1; rf_data_1 = 16'h1357; rf_data_2 = 16'h2468;
    step();
    held = dut_s;
    chk("hold_load_a", ex_op_a, 16'h1357);
    ex_stall = 1'b1; id_rd = 3'd1; id_imm = 16'hFFFF; rf_data_1 = 16'h0F0F; id_mem_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold_cycle%0d", c), dut_s, held);
      chk($sformatf("hold_stall%0d", c), stall_id, 1'b1);
    end

    // randomized traffic against the model
    clear_in();
    rst = 1'b1;
    step();
    m = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs1 = 3'($urandom_range(0, 7)); id_rs2 = 3'($urandom_range(0, 7));
      id_rd = 3'($urandom_range(0, 7)); id_uses_rs2 = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1)); id_alu_op = 4'($urandom_range(0, 15));
      id_imm = 16'($urandom); rf_data_1 = 16'($urandom); rf_data_2 = 16'($urandom);
      ex_alu_result = 16'($urandom);
      mem_rd = 3'($urandom_range(0, 7)); mem_reg_write = 1'($urandom_range(0, 1));
      mem_data = 16'($urandom);
      wb_rd = 3'($urandom_range(0, 7)); wb_reg_write = 1'($urandom_range(0, 1));
      wb_data = 16'($urandom);
      #1 chk("rand_stall_id", stall_id, model_load_use(m) || ex_stall);
      m = model_next(m);
      step();
      chk("rand_state", dut_s, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
